// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bundle between the fetch queue, the instruction memory and decode.
// The master modport is the fetch queue; the slave modport is its environment
// (memory read port, branch unit and decode stage).
interface instr_fetch_queue_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        align_err;

    modport master (
        output mem_addr,
        output instr_valid,
        output instr,
        output instr_pc,
        output align_err,
        input  mem_data,
        input  redirect,
        input  redirect_addr,
        input  instr_ready
    );

    modport slave (
        input  mem_addr,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        input  align_err,
        output mem_data,
        output redirect,
        output redirect_addr,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch sequencer: owns the fetch PC, reads one word per cycle from the
// instruction memory and buffers {pc, word} pairs in a small circular queue
// that decode drains through a valid/ready handshake. A redirect flushes the
// queue and restarts fetch at the word-aligned target.
module instr_fetch_queue #(
    parameter int MEM_BYTES = 64,
    parameter int DEPTH     = 2
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_queue_if.master bus
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = $clog2(DEPTH);

    // Only the address bits inside the memory are kept; the rest are always 0.
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] q_pc   [DEPTH];
    logic [31:0]   q_word [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          align_err;

    logic          pop;
    logic          push;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_target;
    logic          unused_addr_bits;

    // Redirect targets wrap modulo the memory size, so the high bits are ignored.
    assign unused_addr_bits = ^bus.redirect_addr[31:AW];

    assign pop       = (count != '0) & bus.instr_ready;
    assign push      = ~bus.redirect & ((count < (PW+1)'(DEPTH)) | pop);
    assign pc_inc    = fetch_pc + AW'(4);
    assign pc_target = {bus.redirect_addr[AW-1:2], 2'b00};

    assign bus.mem_addr    = {{(32-AW){1'b0}}, fetch_pc};
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = q_word[rd_ptr];
    assign bus.instr_pc    = {{(32-AW){1'b0}}, q_pc[rd_ptr]};
    assign bus.align_err   = align_err;

    // Control state: reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            align_err <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc  <= pc_target;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            align_err <= |bus.redirect_addr[1:0];
        end else begin
            align_err <= 1'b0;
            if (push) begin
                fetch_pc <= pc_inc;
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: capture the word read at the current fetch PC on each push.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_word[wr_ptr] <= bus.mem_data;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a
// randomized run, all compared against a queue-based behavioural model.
module tb_instr_fetch_queue;
    localparam int MEM_BYTES = 64;
    localparam int DEPTH     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    logic [7:0]  mem [MEM_BYTES];
    logic [63:0] m_q [$];
    int          m_pc   = 0;
    bit          m_aerr = 1'b0;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.MEM_BYTES(MEM_BYTES), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Combinational instruction memory: little-endian word at the byte address.
    always_comb begin
        logic [5:0] a;
        a = bus.mem_addr[5:0];
        bus.mem_data = {mem[6'(a + 6'd3)], mem[6'(a + 6'd2)], mem[6'(a + 6'd1)], mem[a]};
    end

    function automatic logic [31:0] word_at(int a);
        return {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
    endfunction

    // Advance the reference model using the inputs now driven, then clock the DUT.
    task automatic step();
        bit pop;
        bit push;
        if (rst) begin
            m_q.delete();
            m_pc   = 0;
            m_aerr = 1'b0;
        end else if (bus.redirect) begin
            m_q.delete();
            m_pc   = int'(bus.redirect_addr % MEM_BYTES) / 4 * 4;
            m_aerr = (bus.redirect_addr[1:0] != 2'b00);
        end else begin
            pop  = (m_q.size() != 0) && bus.instr_ready;
            push = (m_q.size() < DEPTH) || pop;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({32'(m_pc), word_at(m_pc)});
                m_pc = (m_pc + 4) % MEM_BYTES;
            end
            m_aerr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        bus.instr_ready = 1'b0;
        step();
        step();
        total++; if (bus.instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.instr_valid); else passed++;
        total++; if (bus.mem_addr !== 32'h0) $display("[TB] FAIL reset_memaddr: got %h expected 0", bus.mem_addr); else passed++;
        total++; if (bus.align_err !== 1'b0) $display("[TB] FAIL reset_alignerr: got %b expected 0", bus.align_err); else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        total++; if (bus.mem_addr !== 32'h0) $display("[TB] FAIL first_fetch_addr: got %h expected 0", bus.mem_addr); else passed++;
        step();
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.instr_valid !== 1'b1) $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", k, bus.instr_valid); else passed++;
            total++; if (bus.instr_pc !== 32'(k * 4)) $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", k, bus.instr_pc, k * 4); else passed++;
            total++; if (bus.instr !== exp_w[k]) $display("[TB] FAIL stream_word[%0d]: got %h expected %h", k, bus.instr, exp_w[k]); else passed++;
            step();
        end
    endtask

    task automatic test_stall();
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step();
        for (int k = 0; k < 2; k++) begin
            total++; if (bus.instr_valid !== 1'b1) $display("[TB] FAIL stall_valid: got %b expected 1", bus.instr_valid); else passed++;
            total++; if (bus.mem_addr !== 32'h8) $display("[TB] FAIL stall_memaddr: got %h expected 8", bus.mem_addr); else passed++;
            total++; if (bus.instr !== 32'h03020100) $display("[TB] FAIL stall_hold: got %h expected 03020100", bus.instr); else passed++;
            total++; if (bus.instr_pc !== 32'h0) $display("[TB] FAIL stall_hold_pc: got %h expected 0", bus.instr_pc); else passed++;
            step();
        end
        bus.instr_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            total++; if (bus.instr_valid !== 1'b1) $display("[TB] FAIL drain_valid[%0d]: got %b expected 1", k, bus.instr_valid); else passed++;
            total++; if (bus.instr_pc !== 32'(k * 4)) $display("[TB] FAIL drain_pc[%0d]: got %h expected %h", k, bus.instr_pc, k * 4); else passed++;
        end
    endtask

    task automatic test_redirect();
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_addr = 32'h20;
        step();
        bus.redirect = 1'b0;
        total++; if (bus.instr_valid !== 1'b0) $display("[TB] FAIL redir_bubble: got %b expected 0", bus.instr_valid); else passed++;
        total++; if (bus.mem_addr !== 32'h20) $display("[TB] FAIL redir_memaddr: got %h expected 20", bus.mem_addr); else passed++;
        step();
        total++; if (bus.instr_valid !== 1'b1) $display("[TB] FAIL redir_valid: got %b expected 1", bus.instr_valid); else passed++;
        total++; if (bus.instr_pc !== 32'h20) $display("[TB] FAIL redir_pc: got %h expected 20", bus.instr_pc); else passed++;
        total++; if (bus.instr !== 32'h23222120) $display("[TB] FAIL redir_word: got %h expected 23222120", bus.instr); else passed++;
        step();
        total++; if (bus.instr_pc !== 32'h24) $display("[TB] FAIL redir_next_pc: got %h expected 24", bus.instr_pc); else passed++;
    endtask

    task automatic test_misaligned();
        bus.redirect = 1'b1;
        bus.redirect_addr = 32'h47;
        step();
        bus.redirect = 1'b0;
        total++; if (bus.align_err !== 1'b1) $display("[TB] FAIL align_pulse: got %b expected 1", bus.align_err); else passed++;
        total++; if (bus.mem_addr !== 32'h4) $display("[TB] FAIL align_memaddr: got %h expected 4", bus.mem_addr); else passed++;
        step();
        total++; if (bus.align_err !== 1'b0) $display("[TB] FAIL align_clear: got %b expected 0", bus.align_err); else passed++;
        total++; if (bus.instr_pc !== 32'h4) $display("[TB] FAIL align_first_pc: got %h expected 4", bus.instr_pc); else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4] = '{32'h38, 32'h3C, 32'h00, 32'h04};
        logic [31:0] exp_w  [4] = '{32'h3B3A3938, 32'h3F3E3D3C, 32'h03020100, 32'h07060504};
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_addr = 32'h38;
        step();
        bus.redirect = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.instr_valid !== 1'b1) $display("[TB] FAIL wrap_valid[%0d]: got %b expected 1", k, bus.instr_valid); else passed++;
            total++; if (bus.instr_pc !== exp_pc[k]) $display("[TB] FAIL wrap_pc[%0d]: got %h expected %h", k, bus.instr_pc, exp_pc[k]); else passed++;
            total++; if (bus.instr !== exp_w[k]) $display("[TB] FAIL wrap_word[%0d]: got %h expected %h", k, bus.instr, exp_w[k]); else passed++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_addr = 32'h47;
        bus.instr_ready = 1'b1;
        step();
        rst = 1'b0;
        bus.redirect = 1'b0;
        total++; if (bus.instr_valid !== 1'b0) $display("[TB] FAIL rstmid_valid: got %b expected 0", bus.instr_valid); else passed++;
        total++; if (bus.mem_addr !== 32'h0) $display("[TB] FAIL rstmid_memaddr: got %h expected 0", bus.mem_addr); else passed++;
        total++; if (bus.align_err !== 1'b0) $display("[TB] FAIL rstmid_alignerr: got %b expected 0", bus.align_err); else passed++;
        step();
        total++; if (bus.instr_pc !== 32'h0) $display("[TB] FAIL rstmid_restart_pc: got %h expected 0", bus.instr_pc); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.redirect = ($urandom_range(0, 9) == 0);
            bus.redirect_addr = $urandom;
            step();
            total++; if (bus.instr_valid !== (m_q.size() != 0)) $display("[TB] FAIL rand_valid@%0d: got %b expected %b", n, bus.instr_valid, m_q.size() != 0); else passed++;
            total++; if (bus.mem_addr !== 32'(m_pc)) $display("[TB] FAIL rand_memaddr@%0d: got %h expected %h", n, bus.mem_addr, m_pc); else passed++;
            total++; if (bus.align_err !== m_aerr) $display("[TB] FAIL rand_alignerr@%0d: got %b expected %b", n, bus.align_err, m_aerr); else passed++;
            if (m_q.size() != 0) begin
                total++; if (bus.instr_pc !== m_q[0][63:32]) $display("[TB] FAIL rand_pc@%0d: got %h expected %h", n, bus.instr_pc, m_q[0][63:32]); else passed++;
                total++; if (bus.instr !== m_q[0][31:0]) $display("[TB] FAIL rand_word@%0d: got %h expected %h", n, bus.instr, m_q[0][31:0]); else passed++;
            end
        end
        rst = 1'b0;
        bus.redirect = 1'b0;
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
